remote_comm: RTL and testbench
==============================

Name: remote_comm

Overview:
- Host-side command sender that sits directly upstream of the robot's UART command receiver.
- Accepts a 16-bit command on a single-cycle strobe and serialises it as two UART bytes: high byte first, then low byte.
- Presents received response bytes (e.g. 0xA5 ack) to the host logic.
- Instantiates the team's existing UART transceiver (ports rx_rdy, rx_data, clr_rx_rdy, trmt, tx_data, tx_done, RX, TX) and adds byte sequencing, a command holding register and handshakes around it.

Parameters:
TIMEOUT_CYC, 1000000, clk cycles allowed between cmd_snt rising and a response byte arriving (used only with RESP_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
snd_cmd  input  1  single-cycle strobe: send cmd
cmd  input  16  command word, sampled on the cycle snd_cmd is accepted
cmd_snt  output  1  high once both bytes have been transmitted; sticky until next accepted snd_cmd
busy  output  1  high while a command is being serialised (FSM not IDLE)
resp_rdy  output  1  response byte valid (UART rx_rdy)
resp  output  8  response byte (UART rx_data)
clr_resp_rdy  input  1  host clears resp_rdy
resp_timeout  output  1  response timeout flag (tied 0 without RESP_TIMEOUT_EN)
TX  output  1  serial out
RX  input  1  serial in

Behaviour:
- Reset: FSM=IDLE, cmd register=16'h0000, cmd_snt=0, busy=0, resp_timeout=0; TX idles high (UART reset); resp_rdy=0.
- FSM states: IDLE, LD_HI, WAIT_HI, WAIT_LO.
- IDLE:
  - On snd_cmd: latch cmd into a 16-bit holding register, clear cmd_snt, pulse clr_rx_rdy so no stale response remains, go to LD_HI.
  - Without snd_cmd: stay.
- LD_HI: trmt=1 for exactly one cycle, tx_data=hold[15:8], go to WAIT_HI. First trmt occurs 1 cycle after the snd_cmd cycle.
- WAIT_HI: on tx_done, trmt=1 for one cycle with tx_data=hold[7:0], go to WAIT_LO.
- WAIT_LO: on tx_done, set cmd_snt (registered; high the cycle after tx_done), go to IDLE.
- tx_data mux select is driven by the FSM; the holding register guarantees the byte stays stable even if cmd changes after acceptance.
- busy = (state != IDLE).
- snd_cmd while busy: ignored. No latch, no queueing, cmd_snt unaffected.
- snd_cmd in the same cycle that WAIT_LO sees tx_done: ignored (FSM not yet IDLE).
- Response path:
  - resp_rdy = UART rx_rdy; resp = UART rx_data.
  - clr_rx_rdy = clr_resp_rdy OR the accept pulse from IDLE.
  - A new byte arriving overwrites resp and keeps resp_rdy high.
- Reset mid-operation: everything returns to reset values immediately. A partially transmitted byte is abandoned and TX returns high.
- No ordering is enforced between response bytes and commands beyond the accept-time clear.

Optional Feature:
Macro RESP_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears and starts when cmd_snt rises.
  - It stops and clears on resp_rdy.
  - On reaching TIMEOUT_CYC while resp_rdy=0, resp_timeout is set.
  - resp_timeout is sticky; it clears on the next accepted snd_cmd or reset.
  - The counter is inactive while busy or before the first command.
- Undefined: no counter logic; resp_timeout is constant 0.

Test Plan:
- Loopback TX to a UART receiver pair, cmd=16'h2A5C, snd_cmd pulse -> busy=1 next cycle; TX frames 0x2A then 0x5C (start bit, LSB-first data, stop bit); receiver shows 16'h2A5C; cmd_snt=1 one cycle after the second tx_done; busy=0.
- Send 16'h1234; 100 cycles later pulse snd_cmd with cmd=16'hFFFF while busy -> only 0x12, 0x34 transmitted; cmd_snt rises once; no third byte.
- Change cmd input to 16'h0000 the cycle after accepting 16'hBEEF -> bytes on TX are still 0xBE, 0xEF.
- Drive RX with byte 0xA5 -> resp_rdy=1, resp=8'hA5; pulse clr_resp_rdy -> resp_rdy=0 next cycle. Leave 0xA5 pending, then issue snd_cmd -> resp_rdy=0 the cycle after acceptance.
- Assert rst_n=0 during the first byte of 16'h5A5A -> TX=1, busy=0, cmd_snt=0 immediately. After release, send 16'h0102 -> clean 0x01, 0x02 frames.
- RESP_TIMEOUT_EN, TIMEOUT_CYC=200:
  - No response after cmd_snt -> resp_timeout=1 at cycle 200.
  - Response byte at cycle 150 -> resp_timeout stays 0.
  - Next snd_cmd clears the flag.

Source files
------------

// File: rtl/remote_comm.sv
// Host-side command sender: serialises a 16-bit command as two UART bytes (high first)
// and exposes received response bytes. Optional response timeout via RESP_TIMEOUT_EN.

module uart #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy
);
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

    logic          tx_busy_q, tx_done_q;
    logic [BW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_shift_q;

    // Shifter idles at all ones so TX rests high without extra muxing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_busy_q) begin
                if (trmt) begin
                    tx_busy_q  <= 1'b1;
                    tx_shift_q <= {1'b1, tx_data, 1'b0};
                    tx_baud_q  <= '0;
                    tx_bit_q   <= '0;
                end
            end else if (tx_baud_q == BAUD_LAST) begin
                tx_baud_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end else begin
                    tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + 1'b1;
            end
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;

    logic          rx_meta_q, rx_sync_q, rx_busy_q, rx_rdy_q;
    logic [BW-1:0] rx_baud_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q, rx_data_q;

    // Samples mid-bit; start and data bits shift through, stop bit is checked but not stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_rdy_q   <= 1'b0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BAUD_HALF;
                    rx_bit_q  <= '0;
                end
            end else if (rx_baud_q == '0) begin
                rx_baud_q <= BAUD_LAST;
                rx_bit_q  <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    if (rx_sync_q) begin
                        rx_data_q <= rx_shift_q;
                        rx_rdy_q  <= 1'b1;
                    end
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                end
            end else begin
                rx_baud_q <= rx_baud_q - 1'b1;
            end
        end
    end

    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_data_q;
endmodule

module remote_comm #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int BAUD_DIV    = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        cmd_snt,
    output logic        busy,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    input  logic        clr_resp_rdy,
    output logic        resp_timeout,
    output logic        TX,
    input  logic        RX
);
    typedef enum logic [1:0] {IDLE, LD_HI, WAIT_HI, WAIT_LO} state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        cmd_snt_q, cmd_snt_d;
    logic        accept, trmt, tx_done, rx_rdy, clr_rx_rdy;
    logic [7:0]  tx_data, rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= 16'h0000;
            cmd_snt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cmd_snt_q <= cmd_snt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cmd_snt_d = cmd_snt_q;
        accept    = 1'b0;
        trmt      = 1'b0;
        case (state_q)
            IDLE: if (snd_cmd) begin
                accept    = 1'b1;
                hold_d    = cmd;
                cmd_snt_d = 1'b0;
                state_d   = LD_HI;
            end
            LD_HI: begin
                trmt    = 1'b1;
                state_d = WAIT_HI;
            end
            WAIT_HI: if (tx_done) begin
                trmt    = 1'b1;
                state_d = WAIT_LO;
            end
            WAIT_LO: if (tx_done) begin
                cmd_snt_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_data    = (state_q == LD_HI) ? hold_q[15:8] : hold_q[7:0];
    assign clr_rx_rdy = clr_resp_rdy | accept;
    assign busy       = (state_q != IDLE);
    assign cmd_snt    = cmd_snt_q;
    assign resp_rdy   = rx_rdy;
    assign resp       = rx_data;

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy)
    );

`ifdef RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_run_q, resp_timeout_q;

    // Runs only between cmd_snt rising and the first response byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q      <= '0;
            tmo_run_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else if (accept) begin
            tmo_cnt_q      <= '0;
            tmo_run_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else if (cmd_snt_d && !cmd_snt_q) begin
            tmo_cnt_q <= '0;
            tmo_run_q <= 1'b1;
        end else if (tmo_run_q) begin
            if (rx_rdy) begin
                tmo_cnt_q <= '0;
                tmo_run_q <= 1'b0;
            end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                resp_timeout_q <= 1'b1;
                tmo_run_q      <= 1'b0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign resp_timeout = resp_timeout_q;
`else
    // TIMEOUT_CYC has no effect without the counter; this folds to constant 0.
    assign resp_timeout = (TIMEOUT_CYC < 0);
`endif
endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: TX frames are decoded and compared against bytes
// queued when each command is accepted; the response path is driven serially on RX.

module tb_remote_comm;
    localparam int BAUD = 16;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic        clr_resp_rdy = 1'b0;
    logic        RX = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        cmd_snt, busy, resp_rdy, resp_timeout, TX;
    logic [7:0]  resp;

    remote_comm #(.TIMEOUT_CYC(TMO), .BAUD_DIV(BAUD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snd_cmd      (snd_cmd),
        .cmd          (cmd),
        .cmd_snt      (cmd_snt),
        .busy         (busy),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .clr_resp_rdy (clr_resp_rdy),
        .resp_timeout (resp_timeout),
        .TX           (TX),
        .RX           (RX)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    logic [7:0]  sb_q[$];
    int          mon_frames = 0, snt_rises = 0, mon_cnt = 0, mon_idx = 0;
    logic        mon_act = 1'b0, snt_prev = 1'b0;
    logic [9:0]  mon_bits = '0;
    logic [15:0] mon_word = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial decoder on TX, sampling mid-bit on the falling clock edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act  = 1'b0;
            snt_prev = 1'b0;
        end else begin
            if (cmd_snt && !snt_prev) snt_rises++;
            snt_prev = cmd_snt;
            if (!mon_act) begin
                if (TX == 1'b0) begin
                    mon_act = 1'b1;
                    mon_cnt = BAUD / 2 - 1;
                    mon_idx = 0;
                end
            end else if (mon_cnt == 0) begin
                mon_bits[mon_idx] = TX;
                mon_cnt = BAUD - 1;
                mon_idx++;
                if (mon_idx == 10) begin
                    mon_act = 1'b0;
                    $display("tx byte %02h", mon_bits[8:1]);
                    chk("tx_framing", {30'd0, mon_bits[0], mon_bits[9]}, 32'h1);
                    chk("sb_pending", (sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) chk("tx_byte", mon_bits[8:1], sb_q.pop_front());
                    mon_word = {mon_word[7:0], mon_bits[8:1]};
                    mon_frames++;
                end
            end else begin
                mon_cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] c, input bit accepted);
        $display("cmd %04h strobe (expect %s)", c, accepted ? "accept" : "ignore");
        cmd = c;
        snd_cmd = 1'b1;
        if (accepted) begin
            sb_q.push_back(c[15:8]);
            sb_q.push_back(c[7:0]);
        end
        tick();
        snd_cmd = 1'b0;
    endtask

    task automatic wait_snt();
        int n = 0;
        while (!cmd_snt && n < 3000) begin
            tick();
            n++;
        end
        chk("cmd_snt_rise", cmd_snt, 1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        $display("rx byte %02h", b);
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BAUD) tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0, r0;
        repeat (3) tick();
        chk("rst_tx", TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_snt", cmd_snt, 0);
        chk("rst_resp_rdy", resp_rdy, 0);
        chk("rst_timeout", resp_timeout, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic two-byte command
        f0 = mon_frames;
        send_cmd(16'h2A5C, 1);
        chk("busy_after_accept", busy, 1);
        chk("snt_cleared", cmd_snt, 0);
        wait_snt();
        chk("busy_when_snt", busy, 0);
        repeat (30) tick();
        chk("frames_2A5C", mon_frames - f0, 2);
        chk("word_2A5C", mon_word, 16'h2A5C);

        // Strobe while busy is dropped
        f0 = mon_frames;
        r0 = snt_rises;
        send_cmd(16'h1234, 1);
        repeat (100) tick();
        chk("busy_mid_cmd", busy, 1);
        send_cmd(16'hFFFF, 0);
        wait_snt();
        repeat (400) tick();
        chk("frames_1234", mon_frames - f0, 2);
        chk("snt_rises_1234", snt_rises - r0, 1);
        chk("word_1234", mon_word, 16'h1234);
        chk("sb_drained_1234", sb_q.size(), 0);

        // Holding register isolates cmd changes after acceptance
        send_cmd(16'hBEEF, 1);
        cmd = 16'h0000;
        wait_snt();
        repeat (30) tick();
        chk("word_BEEF", mon_word, 16'hBEEF);

        // Response path: ready, overwrite, clear, accept-time clear
        send_rx(8'hA5);
        chk("resp_rdy_A5", resp_rdy, 1);
        chk("resp_A5", resp, 8'hA5);
        send_rx(8'h3C);
        chk("resp_rdy_ovr", resp_rdy, 1);
        chk("resp_ovr", resp, 8'h3C);
        clr_resp_rdy = 1'b1;
        tick();
        clr_resp_rdy = 1'b0;
        chk("resp_rdy_clr", resp_rdy, 0);
        send_rx(8'hA5);
        chk("resp_rdy_pending", resp_rdy, 1);
        send_cmd(16'h0000, 1);
        chk("resp_rdy_accept_clr", resp_rdy, 0);
        wait_snt();
        repeat (30) tick();
        chk("word_0000", mon_word, 16'h0000);

        // Asynchronous reset in the middle of the first byte
        send_cmd(16'h5A5A, 1);
        repeat (BAUD * 4) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", TX, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_snt", cmd_snt, 0);
        sb_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_tx", TX, 1);
        f0 = mon_frames;
        send_cmd(16'h0102, 1);
        wait_snt();
`ifdef RESP_TIMEOUT_EN
        repeat (150) tick();
        chk("tmo_not_yet", resp_timeout, 0);
        repeat (60) tick();
        chk("tmo_fired", resp_timeout, 1);
        chk("frames_0102", mon_frames - f0, 2);
        chk("word_0102", mon_word, 16'h0102);
        send_cmd(16'h0303, 1);
        chk("tmo_cleared", resp_timeout, 0);
        wait_snt();
        send_rx(8'hA5);
        chk("tmo_resp_rdy", resp_rdy, 1);
        repeat (150) tick();
        chk("tmo_suppressed", resp_timeout, 0);
`else
        repeat (250) tick();
        chk("tmo_tied_low", resp_timeout, 0);
        chk("frames_0102", mon_frames - f0, 2);
        chk("word_0102", mon_word, 16'h0102);
`endif
        repeat (50) tick();
        chk("sb_drained_end", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
